// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared constants and helpers for the clkb-domain FIFO drainer
package fifo_rd_pkg;

    localparam int DW_DEF      = 8;
    localparam int PKT_LEN_DEF = 8;
    localparam int HOLD_DEPTH  = 2;

    typedef logic [1:0] occ_t;

    // Width of the packet byte index; never narrower than one bit.
    function automatic int idx_width(input int pkt_len);
        return (pkt_len > 2) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - FIFO read port plus outgoing byte stream
interface fifo_rd_stream_if
    import fifo_rd_pkg::*;
#(
    parameter int DW = DW_DEF
);
    logic          emptyb;
    logic          rreqb;
    logic [DW-1:0] rdatb;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        input  emptyb, rdatb, out_ready,
        output rreqb, out_valid, out_data, out_last
    );

    modport slave (
        output emptyb, rdatb, out_ready,
        input  rreqb, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_rd_skid2.sv
// rtl/fifo_rd_skid2.sv - two-entry ordered holding buffer behind the FIFO read port
module fifo_rd_skid2
    import fifo_rd_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output occ_t          occ_o,
    output logic [DW-1:0] head_o
);
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    occ_t          occ_q, occ_d;
    logic          pop_eff;

    assign pop_eff = pop_i && (occ_q != 2'd0);

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (flush_i) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            case ({push_i, pop_eff})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = push_data_i;
                        occ_d  = 2'd1;
                    end else if (occ_q == 2'd1) begin
                        tail_d = push_data_i;
                        occ_d  = 2'd2;
                    end
                end
                2'b01: begin
                    head_d = tail_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Arriving byte goes behind whatever is still held after the pop.
                    if (occ_q == 2'd1) begin
                        head_d = push_data_i;
                    end else begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(push_i && !pop_eff && occ_q == 2'(HOLD_DEPTH)));

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - drains the dual-clock FIFO read port into a framed byte stream
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int PKT_LEN = PKT_LEN_DEF
) (
    input  logic             clkb,
    input  logic             rstb,
    input  logic             flush,
    fifo_rd_stream_if.master bus
);
    localparam int            IW       = idx_width(PKT_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);

    logic          inflight_q, inflight_d;
    logic [IW-1:0] idx_q, idx_d;
    occ_t          occ;
    logic [DW-1:0] head;
    logic          clear;
    logic          pop;
    logic          rreq;
    logic [2:0]    committed;

    assign clear = flush | rstb;
    assign pop   = (occ != 2'd0) & bus.out_ready;

    // Slots already spoken for once this cycle's pop leaves: held bytes plus the one in flight.
    assign committed = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign rreq      = ~bus.emptyb & ~clear & (committed < 3'(HOLD_DEPTH));

    fifo_rd_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk_i       (clkb),
        .rst_i       (rstb),
        .flush_i     (flush),
        .push_i      (inflight_q & ~clear),
        .push_data_i (bus.rdatb),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_o      (head)
    );

    always_comb begin
        inflight_d = rreq;
        idx_d      = idx_q;
        if (flush) begin
            idx_d = '0;
        end else if (pop) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clkb) begin
        if (rstb) begin
            inflight_q <= 1'b0;
            idx_q      <= '0;
        end else begin
            inflight_q <= inflight_d;
            idx_q      <= idx_d;
        end
    end

    assign bus.rreqb     = rreq;
    assign bus.out_valid = (occ != 2'd0);
    assign bus.out_data  = head;
    assign bus.out_last  = (occ != 2'd0) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - self-checking bench for fifo_rd_stream
module tb_fifo_rd_stream;
    localparam int PKT = 8;

    logic clkb = 1'b0;
    logic rstb;
    logic flush;
    logic flush1;

    always #5 clkb = ~clkb;

    fifo_rd_stream_if #(.DW(8)) bus ();
    fifo_rd_stream_if #(.DW(8)) bus1 ();

    fifo_rd_stream #(.DW(8), .PKT_LEN(PKT)) dut (
        .clkb  (clkb),
        .rstb  (rstb),
        .flush (flush),
        .bus   (bus)
    );

    fifo_rd_stream #(.DW(8), .PKT_LEN(1)) dut1 (
        .clkb  (clkb),
        .rstb  (rstb),
        .flush (flush1),
        .bus   (bus1)
    );

    typedef struct {
        int         nbytes;
        logic [3:0] rdy_pat;
        int         exp_xfers;
        int         exp_lasts;
    } vec_t;

    vec_t vecs[6];

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] fifo_q[$];
    logic [7:0] sb[$];
    int         beat_cnt = 0;
    bit         rd_last  = 1'b0;
    bit         prev_rs  = 1'b0;
    int         cyc      = 0;
    int         pops1    = 0;
    bit         last_rq, last_valid, last_pop, last_last;
    logic [7:0] last_data, last_rd_byte;
    logic [7:0] cnt1 = 8'h00;
    logic [7:0] exp1 = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_bytes(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + 8'(i)));
        if (n > 0) bus.emptyb = 1'b0;
    endtask

    // One clkb cycle: drive inputs, compare against the model, advance the FIFO model.
    task automatic step(input logic rdy, input logic fl, input logic rs);
        int         held;
        bit         pop, exp_rq, rd_now, rd1, pop1;
        logic [7:0] b;
        bus.out_ready  = rdy;
        flush          = fl;
        rstb           = rs;
        bus1.out_ready = 1'($urandom_range(0, 1));
        #2;
        held = sb.size() - int'(rd_last);
        pop  = bus.out_valid && rdy;
        check("out_valid", bus.out_valid, held > 0);
        if (prev_rs) begin
            check("rst_out_data", bus.out_data, 0);
            check("rst_out_last", bus.out_last, 0);
            check("pkt1_rst_valid", bus1.out_valid, 0);
        end
        if (held > 0) begin
            check("out_data", bus.out_data, sb[0]);
            check("out_last", bus.out_last, beat_cnt == PKT - 1);
        end
        exp_rq = !bus.emptyb && !fl && !rs && ((sb.size() - int'(pop)) < 2);
        check("rreqb", bus.rreqb, exp_rq);
        last_rq    = bus.rreqb;
        last_valid = bus.out_valid;
        last_pop   = pop;
        last_data  = bus.out_data;
        last_last  = bus.out_last;

        if (pop && sb.size() > 0) begin
            void'(sb.pop_front());
            beat_cnt = (beat_cnt + 1) % PKT;
        end
        if (fl || rs) begin
            sb.delete();
            beat_cnt = 0;
        end
        rd_now = bus.rreqb && (fifo_q.size() > 0);
        b      = 8'h00;
        if (rd_now) begin
            b            = fifo_q.pop_front();
            last_rd_byte = b;
            if (!(fl || rs)) sb.push_back(b);
        end

        pop1 = bus1.out_valid && bus1.out_ready;
        if (pop1) begin
            check("pkt1_last", bus1.out_last, 1);
            check("pkt1_data", bus1.out_data, exp1);
            exp1 = exp1 + 8'd1;
            pops1++;
        end
        rd1 = bus1.rreqb;
        if (rs) exp1 = cnt1;

        prev_rs = rs;
        @(posedge clkb);
        #1;
        bus.rdatb  = rd_now ? b : 8'($urandom);
        bus.emptyb = (fifo_q.size() == 0);
        rd_last    = rd_now && !(fl || rs);
        bus1.rdatb = rd1 ? cnt1 : 8'($urandom);
        if (rd1) cnt1 = cnt1 + 8'd1;
        cyc++;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        bus.emptyb = 1'b1;
        step(1'b0, 1'b0, 1'b1);
    endtask

    int         first_rq, first_v, first_x, last_x, nx, nl, nr, lastok, got, c, c0;
    logic [7:0] skip, first_d;

    initial begin
        bus.emptyb     = 1'b1;
        bus.rdatb      = 8'h00;
        bus.out_ready  = 1'b0;
        bus1.emptyb    = 1'b0;
        bus1.rdatb     = 8'h00;
        bus1.out_ready = 1'b0;
        flush          = 1'b0;
        flush1         = 1'b0;
        rstb           = 1'b1;

        vecs[0] = '{16, 4'b1111, 16, 2};
        vecs[1] = '{20, 4'b1001, 20, 2};
        vecs[2] = '{3,  4'b1111, 3,  0};
        vecs[3] = '{8,  4'b0101, 8,  1};
        vecs[4] = '{1,  4'b1111, 1,  0};
        vecs[5] = '{24, 4'b0011, 24, 3};

        repeat (2) @(posedge clkb);
        #1;
        prev_rs = 1'b1;

        // Continuous stream: latency, back-to-back bytes, framing.
        do_reset();
        push_bytes(16, 8'h00);
        first_rq = -1; first_v = -1; first_x = -1; last_x = -1;
        nx = 0; nl = 0; lastok = 0;
        c0 = cyc;
        for (int i = 0; i < 40; i++) begin
            c = cyc;
            step(1'b1, 1'b0, 1'b0);
            if (last_rq && first_rq < 0) first_rq = c;
            if (last_valid && first_v < 0) first_v = c;
            if (last_pop) begin
                if (first_x < 0) first_x = c;
                last_x = c;
                nx++;
                if (last_last) begin
                    nl++;
                    if (last_data == 8'h07 || last_data == 8'h0F) lastok++;
                end
            end
        end
        check("lat_rreq_immediate", first_rq - c0, 0);
        check("lat_first_valid", first_v - first_rq, 2);
        check("stream_consecutive", last_x - first_x, 15);
        check("stream_count", nx, 16);
        check("stream_lasts", nl, 2);
        check("stream_last_pos", lastok, 2);

        // Table: byte counts against ready patterns.
        foreach (vecs[v]) begin
            do_reset();
            push_bytes(vecs[v].nbytes, 8'(8'h80 + 8'(16 * v)));
            nx = 0; nl = 0; nr = 0;
            for (int i = 0; i < 200; i++) begin
                step(vecs[v].rdy_pat[i % 4], 1'b0, 1'b0);
                nr += int'(last_rq);
                nx += int'(last_pop);
                nl += int'(last_pop && last_last);
            end
            check("vec_xfers", nx, vecs[v].exp_xfers);
            check("vec_lasts", nl, vecs[v].exp_lasts);
            check("vec_rreqs", nr, vecs[v].nbytes);
            check("vec_drained_valid", last_valid, 0);
        end

        // Flush while a read is in flight.
        do_reset();
        push_bytes(32, 8'h40);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        check("flush_setup_inflight", last_rq, 1);
        skip = last_rd_byte;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("flush_valid_next", last_valid, 0);
        nx = 0; got = 0; first_d = 8'h00;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                if (nx == 0) first_d = last_data;
                nx++;
                if (last_last) got = nx;
            end
        end
        check("flush_skips_inflight", first_d, 8'(skip + 8'd1));
        check("flush_idx_restart", got, 8);

        // Reset while the 5th byte of a packet is presented.
        do_reset();
        push_bytes(40, 8'h10);
        nx = 0;
        for (int i = 0; i < 30 && nx < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            nx += int'(last_pop);
        end
        check("mrst_setup", nx, 4);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("mrst_valid", last_valid, 0);
        nx = 0; got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (last_pop) begin
                nx++;
                if (last_last) got = nx;
            end
        end
        check("mrst_next_last", got, 8);

        // Random traffic, backpressure, flushes and resets against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) < 4) push_bytes($urandom_range(1, 2), 8'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, $urandom_range(0, 499) == 0);
        end

        check("pkt1_activity", pops1 > 0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
